// File: rtl/sipiso_alu_host.sv
// Host side of a serial-in/parallel-in, serial-out ALU link: streams OP_A, loads OP_B,
// then collects the 4-bit serial result or gives up after TIMEOUT_CYC wait cycles.
//
// state  | meaning
// IDLE   | op_ready high, waiting for a request
// SEND_A | four cycles shifting captured op_a out on a, LSB first
// LOAD_B | one cycle presenting captured op_b with loadb
// WAIT_C | counting cycles until the ALU raises startc
// RECV_C | shifting result bits 1..3 into the shadow register
// DONE   | one cycle of res_valid, or of timeout when the wait expired
module sipiso_alu_host #(
  parameter int TIMEOUT_CYC = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       op_valid,
  output logic       op_ready,
  input  logic [3:0] op_a,
  input  logic [3:0] op_b,
  output logic       res_valid,
  output logic [3:0] res,
  output logic       timeout,
  output logic       starta,
  output logic       a,
  output logic       loadb,
  output logic [3:0] b,
  input  logic       startc,
  input  logic       c
);

  typedef enum logic [2:0] {IDLE, SEND_A, LOAD_B, WAIT_C, RECV_C, DONE} state_t;

  state_t     state, state_nxt;
  logic [1:0] bit_cnt, bit_cnt_nxt;
  logic [7:0] wait_cnt, wait_cnt_nxt;
  logic [3:0] shadow, shadow_nxt;
  logic [3:0] opa_q, opa_nxt;
  logic [3:0] opb_q, opb_nxt;
  logic [3:0] res_nxt;
  logic       tmo_q, tmo_nxt;

  logic       op_ready_nxt, res_valid_nxt, timeout_nxt;
  logic       starta_nxt, a_nxt, loadb_nxt;
  logic [3:0] b_nxt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      bit_cnt   <= 2'd0;
      wait_cnt  <= 8'd0;
      shadow    <= 4'd0;
      opa_q     <= 4'd0;
      opb_q     <= 4'd0;
      tmo_q     <= 1'b0;
      op_ready  <= 1'b1;
      res_valid <= 1'b0;
      res       <= 4'd0;
      timeout   <= 1'b0;
      starta    <= 1'b0;
      a         <= 1'b0;
      loadb     <= 1'b0;
      b         <= 4'd0;
    end else begin
      state     <= state_nxt;
      bit_cnt   <= bit_cnt_nxt;
      wait_cnt  <= wait_cnt_nxt;
      shadow    <= shadow_nxt;
      opa_q     <= opa_nxt;
      opb_q     <= opb_nxt;
      tmo_q     <= tmo_nxt;
      op_ready  <= op_ready_nxt;
      res_valid <= res_valid_nxt;
      res       <= res_nxt;
      timeout   <= timeout_nxt;
      starta    <= starta_nxt;
      a         <= a_nxt;
      loadb     <= loadb_nxt;
      b         <= b_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    bit_cnt_nxt  = bit_cnt;
    wait_cnt_nxt = wait_cnt;
    shadow_nxt   = shadow;
    opa_nxt      = opa_q;
    opb_nxt      = opb_q;
    res_nxt      = res;
    tmo_nxt      = tmo_q;

    case (state)
      IDLE: begin
        if (op_valid) begin
          opa_nxt     = op_a;
          opb_nxt     = op_b;
          bit_cnt_nxt = 2'd0;
          state_nxt   = SEND_A;
        end
      end
      SEND_A: begin
        bit_cnt_nxt = bit_cnt + 2'd1;
        if (bit_cnt == 2'd3) state_nxt = LOAD_B;
      end
      LOAD_B: begin
        wait_cnt_nxt = 8'd0;
        state_nxt    = WAIT_C;
      end
      WAIT_C: begin
        wait_cnt_nxt = wait_cnt + 8'd1;
        // startc takes priority over an expiring wait in the same cycle
        if (startc) begin
          shadow_nxt  = {c, 3'b000};
          bit_cnt_nxt = 2'd1;
          state_nxt   = RECV_C;
        end else if (wait_cnt + 8'd1 == 8'(TIMEOUT_CYC)) begin
          tmo_nxt   = 1'b1;
          state_nxt = DONE;
        end
      end
      RECV_C: begin
        shadow_nxt  = {c, shadow[3:1]};
        bit_cnt_nxt = bit_cnt + 2'd1;
        if (bit_cnt == 2'd3) begin
          res_nxt     = {c, shadow[3:1]};
          tmo_nxt     = 1'b0;
          bit_cnt_nxt = 2'd0;
          state_nxt   = DONE;
        end
      end
      DONE: begin
        tmo_nxt   = 1'b0;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    // Outputs are registered from the next-state view so they align with the state they belong to.
    op_ready_nxt  = (state_nxt == IDLE);
    starta_nxt    = (state_nxt == SEND_A) && (state == IDLE);
    a_nxt         = (state_nxt == SEND_A) ? opa_nxt[bit_cnt_nxt] : 1'b0;
    loadb_nxt     = (state_nxt == LOAD_B);
    b_nxt         = (state_nxt == LOAD_B) ? opb_nxt : 4'd0;
    res_valid_nxt = (state_nxt == DONE) && !tmo_nxt;
    timeout_nxt   = (state_nxt == DONE) && tmo_nxt;
  end

endmodule

// File: tb/tb_sipiso_alu_host.sv
// Scoreboard bench for sipiso_alu_host: drives requests and a scripted ALU response,
// records outputs per cycle relative to the handshake cycle, and checks them per scenario.
module tb_sipiso_alu_host;

  logic       clk;
  logic       reset;
  logic       op_valid;
  logic       op_ready;
  logic [3:0] op_a;
  logic [3:0] op_b;
  logic       res_valid;
  logic [3:0] res;
  logic       timeout;
  logic       starta;
  logic       a;
  logic       loadb;
  logic [3:0] b;
  logic       startc;
  logic       c;

  int total = 0;
  int bad   = 0;
  logic [3:0] exp_q[$];

  logic       obs_ready  [0:63];
  logic       obs_starta [0:63];
  logic       obs_a      [0:63];
  logic       obs_loadb  [0:63];
  logic       obs_rv     [0:63];
  logic       obs_to     [0:63];
  logic [3:0] obs_b      [0:63];
  logic [3:0] obs_res    [0:63];
  logic [63:0] rv_mask, to_mask, ready_mask;

  sipiso_alu_host #(.TIMEOUT_CYC(8)) dut (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op_ready(op_ready),
    .op_a(op_a), .op_b(op_b), .res_valid(res_valid), .res(res), .timeout(timeout),
    .starta(starta), .a(a), .loadb(loadb), .b(b), .startc(startc), .c(c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog expired at time %0t", $time);
    $fatal(1, "watchdog");
  end

  // Current cycle is cycle 0 (handshake). Records outputs of cycles 1..ncyc;
  // garbage operands are driven after the handshake to show they are not re-captured.
  task automatic run_op(input logic [3:0] oa, input logic [3:0] ob, input int k,
                        input logic [3:0] cw, input int ncyc, input bit hold,
                        input logic [63:0] spur, input int rst_cyc, input bit push);
    op_valid = 1'b1; op_a = oa; op_b = ob; reset = 1'b1;
    startc = spur[0]; c = 1'($urandom_range(0, 1));
    if (push) exp_q.push_back(cw);
    rv_mask = '0; to_mask = '0; ready_mask = '0;
    for (int i = 0; i < 64; i++) begin
      obs_ready[i] = 0; obs_starta[i] = 0; obs_a[i] = 0; obs_loadb[i] = 0;
      obs_rv[i] = 0; obs_to[i] = 0; obs_b[i] = 0; obs_res[i] = 0;
    end
    for (int cyc = 1; cyc <= ncyc; cyc++) begin
      @(posedge clk); #1;
      obs_ready[cyc] = op_ready; obs_starta[cyc] = starta; obs_a[cyc] = a;
      obs_loadb[cyc] = loadb; obs_b[cyc] = b; obs_rv[cyc] = res_valid;
      obs_to[cyc] = timeout; obs_res[cyc] = res;
      rv_mask[cyc] = res_valid; to_mask[cyc] = timeout; ready_mask[cyc] = op_ready;
      op_valid = hold; op_a = ~oa; op_b = ~ob;
      reset  = (cyc == rst_cyc) ? 1'b0 : 1'b1;
      startc = ((k > 0) && (cyc == k)) || spur[cyc];
      c = ((k > 0) && (cyc >= k) && (cyc <= k + 3)) ? cw[cyc - k] : 1'($urandom_range(0, 1));
    end
  endtask

  task automatic test_reset();
    logic [9:0] got;
    reset = 1'b0; op_valid = 1'b1; op_a = 4'hF; op_b = 4'hF; startc = 1'b1; c = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    got = {starta, a, loadb, b, op_ready, res_valid, timeout};
    total++;
    if (got !== 10'b0_0_0_0000_1_0_0) begin
      bad++; $display("FAIL reset_outputs got=%b exp=%b", got, 10'b0_0_0_0000_1_0_0);
    end
    total++;
    if (res !== 4'h0) begin bad++; $display("FAIL reset_res got=%h exp=0", res); end
    startc = 1'b0; op_valid = 1'b0;
  endtask

  task automatic test_basic();
    logic [3:0] oa;
    logic [3:0] e;
    logic [9:0] got, expv;
    oa = 4'b1011;
    run_op(oa, 4'h6, 9, 4'b1001, 14, 1'b0, 64'h0, -1, 1'b1);
    for (int cyc = 1; cyc <= 14; cyc++) begin
      expv = {cyc == 1, (cyc <= 4) ? oa[cyc - 1] : 1'b0, cyc == 5,
              (cyc == 5) ? 4'h6 : 4'h0, cyc == 14, cyc == 13, 1'b0};
      got = {obs_starta[cyc], obs_a[cyc], obs_loadb[cyc], obs_b[cyc],
             obs_ready[cyc], obs_rv[cyc], obs_to[cyc]};
      total++;
      if (got !== expv) begin
        bad++; $display("FAIL basic_outputs cyc=%0d got=%b exp=%b", cyc, got, expv);
      end
    end
    for (int cyc = 1; cyc <= 14; cyc++) if (obs_rv[cyc] === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin bad++; $display("FAIL basic_res unexpected result cyc=%0d", cyc); end
      else begin
        e = exp_q.pop_front();
        if (obs_res[cyc] !== e) begin bad++; $display("FAIL basic_res got=%h exp=%h", obs_res[cyc], e); end
      end
    end
    total++;
    if (obs_res[14] !== 4'h9) begin bad++; $display("FAIL basic_res_hold got=%h exp=9", obs_res[14]); end
  endtask

  task automatic test_first_wait();
    logic [3:0] e;
    run_op(4'h3, 4'h5, 6, 4'hA, 11, 1'b0, 64'h0, -1, 1'b1);
    total++;
    if (rv_mask !== (64'h1 << 10)) begin bad++; $display("FAIL first_wait_rv got=%h exp=%h", rv_mask, 64'h1 << 10); end
    total++;
    if (ready_mask !== (64'h1 << 11)) begin bad++; $display("FAIL first_wait_ready got=%h exp=%h", ready_mask, 64'h1 << 11); end
    for (int cyc = 1; cyc <= 11; cyc++) if (obs_rv[cyc] === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin bad++; $display("FAIL first_wait_res unexpected result cyc=%0d", cyc); end
      else begin
        e = exp_q.pop_front();
        if (obs_res[cyc] !== e) begin bad++; $display("FAIL first_wait_res got=%h exp=%h", obs_res[cyc], e); end
      end
    end
  endtask

  task automatic test_timeout();
    run_op(4'h7, 4'h1, 0, 4'h0, 15, 1'b0, 64'h0, -1, 1'b0);
    total++;
    if (to_mask !== (64'h1 << 14)) begin bad++; $display("FAIL timeout_pulse got=%h exp=%h", to_mask, 64'h1 << 14); end
    total++;
    if (rv_mask !== 64'h0) begin bad++; $display("FAIL timeout_no_rv got=%h exp=0", rv_mask); end
    total++;
    if (ready_mask !== (64'h1 << 15)) begin bad++; $display("FAIL timeout_ready got=%h exp=%h", ready_mask, 64'h1 << 15); end
    total++;
    if (obs_res[15] !== 4'hA || obs_res[14] !== 4'hA) begin
      bad++; $display("FAIL timeout_res_kept got=%h/%h exp=a", obs_res[14], obs_res[15]);
    end
  endtask

  task automatic test_timeout_race();
    logic [3:0] e;
    run_op(4'h2, 4'h8, 13, 4'h5, 18, 1'b0, 64'h0, -1, 1'b1);
    total++;
    if (to_mask !== 64'h0) begin bad++; $display("FAIL race_no_timeout got=%h exp=0", to_mask); end
    total++;
    if (rv_mask !== (64'h1 << 17)) begin bad++; $display("FAIL race_rv got=%h exp=%h", rv_mask, 64'h1 << 17); end
    for (int cyc = 1; cyc <= 18; cyc++) if (obs_rv[cyc] === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin bad++; $display("FAIL race_res unexpected result cyc=%0d", cyc); end
      else begin
        e = exp_q.pop_front();
        if (obs_res[cyc] !== e) begin bad++; $display("FAIL race_res got=%h exp=%h", obs_res[cyc], e); end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0] e;
    logic [9:0] got;
    run_op(4'hB, 4'h3, 0, 4'h0, 4, 1'b0, 64'h8, 3, 1'b0);
    got = {obs_starta[4], obs_a[4], obs_loadb[4], obs_b[4], obs_ready[4], obs_rv[4], obs_to[4]};
    total++;
    if (got !== 10'b0_0_0_0000_1_0_0) begin
      bad++; $display("FAIL reset_mid_outputs got=%b exp=%b", got, 10'b0_0_0_0000_1_0_0);
    end
    total++;
    if (obs_res[4] !== 4'h0) begin bad++; $display("FAIL reset_mid_res got=%h exp=0", obs_res[4]); end
    total++;
    if ((rv_mask | to_mask) !== 64'h0) begin bad++; $display("FAIL reset_mid_pulses got=%h exp=0", rv_mask | to_mask); end
    run_op(4'hC, 4'h2, 8, 4'h6, 13, 1'b0, 64'h0, -1, 1'b1);
    total++;
    if ({obs_a[4], obs_a[3], obs_a[2], obs_a[1]} !== 4'hC || obs_starta[1] !== 1'b1) begin
      bad++; $display("FAIL reset_mid_resend got=%h exp=c", {obs_a[4], obs_a[3], obs_a[2], obs_a[1]});
    end
    total++;
    if (rv_mask !== (64'h1 << 12)) begin bad++; $display("FAIL reset_mid_rv got=%h exp=%h", rv_mask, 64'h1 << 12); end
    for (int cyc = 1; cyc <= 13; cyc++) if (obs_rv[cyc] === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin bad++; $display("FAIL reset_mid_res unexpected result cyc=%0d", cyc); end
      else begin
        e = exp_q.pop_front();
        if (obs_res[cyc] !== e) begin bad++; $display("FAIL reset_mid_res got=%h exp=%h", obs_res[cyc], e); end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] e;
    run_op(4'h5, 4'h9, 7, 4'h3, 12, 1'b1, 64'h204, -1, 1'b1);
    total++;
    if ({obs_a[4], obs_a[3], obs_a[2], obs_a[1]} !== 4'h5 || obs_b[5] !== 4'h9) begin
      bad++; $display("FAIL b2b_op1_operands got=%h/%h exp=5/9", {obs_a[4], obs_a[3], obs_a[2], obs_a[1]}, obs_b[5]);
    end
    total++;
    if (rv_mask !== (64'h1 << 11)) begin bad++; $display("FAIL b2b_op1_rv got=%h exp=%h", rv_mask, 64'h1 << 11); end
    for (int cyc = 1; cyc <= 12; cyc++) if (obs_rv[cyc] === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin bad++; $display("FAIL b2b_op1_res unexpected result cyc=%0d", cyc); end
      else begin
        e = exp_q.pop_front();
        if (obs_res[cyc] !== e) begin bad++; $display("FAIL b2b_op1_res got=%h exp=%h", obs_res[cyc], e); end
      end
    end
    run_op(4'hA, 4'h4, 8, 4'hE, 13, 1'b0, 64'h403, -1, 1'b1);
    total++;
    if (obs_starta[1] !== 1'b1 || {obs_a[4], obs_a[3], obs_a[2], obs_a[1]} !== 4'hA || obs_b[5] !== 4'h4) begin
      bad++; $display("FAIL b2b_op2_operands got=%b/%h/%h exp=1/a/4", obs_starta[1],
                      {obs_a[4], obs_a[3], obs_a[2], obs_a[1]}, obs_b[5]);
    end
    total++;
    if (rv_mask !== (64'h1 << 12)) begin bad++; $display("FAIL b2b_op2_rv got=%h exp=%h", rv_mask, 64'h1 << 12); end
    for (int cyc = 1; cyc <= 13; cyc++) if (obs_rv[cyc] === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin bad++; $display("FAIL b2b_op2_res unexpected result cyc=%0d", cyc); end
      else begin
        e = exp_q.pop_front();
        if (obs_res[cyc] !== e) begin bad++; $display("FAIL b2b_op2_res got=%h exp=%h", obs_res[cyc], e); end
      end
    end
    total++;
    if (exp_q.size() != 0) begin bad++; $display("FAIL scoreboard_drained got=%0d exp=0", exp_q.size()); end
  endtask

  initial begin
    reset = 1'b0; op_valid = 1'b0; op_a = 4'h0; op_b = 4'h0; startc = 1'b0; c = 1'b0;
    test_reset();
    test_basic();
    test_first_wait();
    test_timeout();
    test_timeout_race();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sipiso_alu_host.md
SIPISO_ALU_HOST -- requirements
Module: sipiso_alu_host

Interface
REQ-001 Parameter TIMEOUT_CYC, default 64: maximum number of WAIT_C cycles before an operation is abandoned; legal range 2..255.
REQ-002 CLK  input  1  single clock; all state updates on the rising edge.
REQ-003 RESET  input  1  synchronous, active-low reset, sampled on the CLK rising edge.
REQ-004 OP_VALID  input  1  user request; operands OP_A and OP_B are valid.
REQ-005 OP_READY  output  1  block is idle and accepts a request.
REQ-006 OP_A  input  4  operand streamed serially to the ALU, LSB first.
REQ-007 OP_B  input  4  operand loaded in parallel into the ALU.
REQ-008 RES_VALID  output  1  one-cycle pulse; RES holds a new result.
REQ-009 RES  output  4  deserialized ALU result.
REQ-010 TIMEOUT  output  1  one-cycle pulse; no STARTC arrived within TIMEOUT_CYC cycles.
REQ-011 STARTA  output  1  strobe marking the first serial bit on A.
REQ-012 A  output  1  serial operand bit.
REQ-013 LOADB  output  1  one-cycle strobe; B is valid.
REQ-014 B  output  4  parallel operand to the ALU.
REQ-015 STARTC  input  1  ALU strobe marking result bit 0 on C.
REQ-016 C  input  1  serial result bit from the ALU, LSB first.

Function
REQ-017 The FSM SHALL have the states IDLE, SEND_A, LOAD_B, WAIT_C, RECV_C and DONE, with OP_READY=1 only in IDLE.
REQ-018 A handshake is accepted in cycle 0 when OP_VALID=1 and OP_READY=1; the block SHALL capture OP_A and OP_B into internal registers and go to SEND_A.
REQ-019 SEND_A lasts exactly 4 cycles (cycles 1-4): A=OP_A[i] in cycle i+1, and STARTA=1 in cycle 1 only.
REQ-020 LOAD_B lasts 1 cycle (cycle 5): LOADB=1 and B=captured OP_B; B SHALL be 0 in every other cycle.
REQ-021 WAIT_C starts in cycle 6, and a wait counter SHALL clear on entry and increment every cycle spent in WAIT_C.
REQ-022 STARTC=1 in WAIT_C (cycle k): the block SHALL capture C into RES bit 0 and go to RECV_C, including in the first WAIT_C cycle (cycle 6).
REQ-023 RECV_C lasts 3 cycles (k+1..k+3): C SHALL be shifted into RES bits 1, 2 and 3 in that order.
REQ-024 STARTC SHALL be ignored in RECV_C (no restart) and in IDLE, SEND_A and LOAD_B.
REQ-025 DONE lasts 1 cycle (k+4): RES_VALID=1 and RES=assembled word.
REQ-026 The block SHALL return to IDLE with OP_READY=1 at k+5.
REQ-027 RES SHALL hold its value until the next RES_VALID; it is not updated on a timeout.
REQ-028 The result SHALL be assembled in a shadow shift register so that RES changes only in DONE.
REQ-029 Timeout: the wait counter reaching TIMEOUT_CYC without STARTC SHALL pulse TIMEOUT=1 for one cycle with no RES_VALID, and the FSM SHALL return to IDLE the next cycle.
REQ-030 If STARTC=1 in the same cycle the counter reaches TIMEOUT_CYC, STARTC SHALL win: no timeout, and the block enters RECV_C.
REQ-031 OP_VALID while OP_READY=0 SHALL be ignored, and the captured operands SHALL NOT change mid-operation.
REQ-032 Back-to-back operation: OP_VALID=1 in the cycle OP_READY returns high SHALL be accepted in that cycle.
REQ-033 STARTA, A and LOADB SHALL be 0 outside the cycles defined in REQ-019 and REQ-020.
REQ-034 The outputs SHALL be glitch-free registered signals: no combinational path from any input to any output.

Reset
REQ-035 RESET=0 at a rising edge SHALL force state IDLE, OP_READY=1, RES_VALID=0, RES=0, TIMEOUT=0, STARTA=0, A=0, LOADB=0, B=0, wait counter=0 and bit counter=0.
REQ-036 Reset mid-operation (any state) SHALL abort the operation without a RES_VALID or TIMEOUT pulse, and STARTC seen during reset SHALL be ignored.
REQ-037 The first request SHALL be accepted in the first cycle with RESET=1.

Verification
REQ-038 OP_A=4'b1011, OP_B=4'h6 -> STARTA in cycle 1, A=1,1,0,1 in cycles 1-4, LOADB=1 with B=6 in cycle 5; then the ALU model returns STARTC at cycle 9 with C=1,0,0,1 -> RES_VALID at cycle 13, RES=4'h9, OP_READY=1 at cycle 14.
REQ-039 STARTC in cycle 6, the first WAIT_C cycle -> RES_VALID at cycle 10.
REQ-040 No STARTC with TIMEOUT_CYC=8 -> TIMEOUT pulse after 8 WAIT_C cycles, RES unchanged from the prior value, OP_READY high the next cycle.
REQ-041 STARTC coinciding with the timeout cycle -> no TIMEOUT, and the result is received.
REQ-042 RESET=0 asserted in cycle 3 of SEND_A -> next cycle IDLE with all outputs at reset values; a new request completes normally.
REQ-043 Back-to-back operations with OP_VALID held high and spurious STARTC pulses during SEND_A and RECV_C -> both results correct, each with exactly one RES_VALID.
